data_demod: RTL and testbench

Receive-side counterpart of the modulator datapath. Accepts the 5-bit `dmod` symbol stream qualified by `mod_en`, reassembles two nibble symbols into one byte, buffers bytes in an internal 2^DEPTH x WIDTH FIFO, and presents them to a byte consumer through a read-enable handshake. Framing violations and overflow are detected, counted and flagged.

---
 rtl/data_demod.sv | 109 ++++++++++
 tb/tb_data_demod.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_demod.sv
// Nibble-pair demodulator: joins marker-tagged 5-bit symbols into bytes and buffers them in a 2^DEPTH FIFO.
// A byte enters the FIFO on its low-nibble edge, and a read returns data one cycle after rd_en. A full FIFO drops the byte and sets sticky overflow.
module data_demod #(
  parameter int DEPTH     = 6,
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 1 << DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mod_en,
  input  logic [4:0]       dmod,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   level,
  output logic             frame_err,
  output logic [7:0]       err_cnt,
  output logic             overflow
);

  typedef enum logic {S_HI, S_LO} state_t;

  localparam logic [DEPTH:0] LVL_MAX = (DEPTH+1)'(MAX_COUNT);

  state_t           state, state_nxt;
  logic [3:0]       held, held_nxt;
  logic             wr_req, ferr_nxt;
  logic [WIDTH-1:0] wr_byte;
  logic             wr_ok, rd_ok;
  logic [DEPTH-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [MAX_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_HI;
      held  <= 4'h0;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    if (mod_en) begin
      case (state)
        S_HI: if (dmod[4]) begin
          state_nxt = S_LO;
          held_nxt  = dmod[3:0];
        end
        S_LO: if (dmod[4]) begin
          // Truncated byte: the new high nibble restarts the pair.
          held_nxt = dmod[3:0];
        end else begin
          state_nxt = S_HI;
        end
        default: state_nxt = S_HI;
      endcase
    end
  end

  always_comb begin
    wr_req   = mod_en && (state == S_LO) && !dmod[4];
    ferr_nxt = mod_en && ((state == S_HI) ? !dmod[4] : dmod[4]);
    wr_byte  = {held, dmod[3:0]};
  end

  // Accept decisions use pre-edge flags, so a same-cycle read never frees room for a write.
  assign wr_ok = wr_req && !full;
  assign rd_ok = rd_en && !empty;
  assign empty = (level == '0);
  assign full  = (level == LVL_MAX);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= 8'd0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= ferr_nxt;
      data_valid <= rd_ok;
      if (ferr_nxt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (wr_req && full) overflow <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_data_demod.sv
// Directed bench for data_demod: hand-computed expectations checked by immediate assertions.
module tb_data_demod;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mod_en = 1'b0;
  logic [4:0] dmod = 5'h00;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, empty, full, frame_err, overflow;
  logic [6:0] level;
  logic [7:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_demod dut (
    .clk(clk), .reset(reset), .mod_en(mod_en), .dmod(dmod), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .empty(empty), .full(full),
    .level(level), .frame_err(frame_err), .err_cnt(err_cnt), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [4:0] s, input logic rd);
    mod_en = 1'b1;
    dmod   = s;
    rd_en  = rd;
    tick();
    mod_en = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic rd);
    sym({1'b1, b[7:4]}, 1'b0);
    sym({1'b0, b[3:0]}, rd);
  endtask

  task automatic rd_one(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, data_valid, 1);
    chk(tag, data_out, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_dvld"}, data_valid, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    chk_reset_state("rst");

    // Basic byte 0xA5
    sym(5'h1A, 1'b0);
    chk("a5_hi_level", level, 0);
    sym(5'h05, 1'b0);
    chk("a5_level", level, 1);
    chk("a5_empty", empty, 0);
    rd_one("a5_data", 8'hA5);
    chk("a5_empty_after", empty, 1);
    tick();
    chk("a5_vld_pulse", data_valid, 0);
    chk("a5_dout_hold", data_out, 8'hA5);

    // Framing errors
    sym(5'h03, 1'b0);
    chk("orphan_ferr", frame_err, 1);
    chk("orphan_cnt", err_cnt, 1);
    sym(5'h12, 1'b0);
    chk("hi_ferr_clear", frame_err, 0);
    sym(5'h17, 1'b0);
    chk("trunc_ferr", frame_err, 1);
    sym(5'h04, 1'b0);
    chk("trunc_ferr_clear", frame_err, 0);
    chk("trunc_cnt", err_cnt, 2);
    chk("trunc_level", level, 1);

    // Idle gap mid-byte keeps the held nibble
    sym(5'h1B, 1'b0);
    tick(); tick(); tick();
    sym(5'h0C, 1'b0);
    chk("gap_level", level, 2);
    chk("gap_cnt", err_cnt, 2);
    rd_one("err_byte", 8'h74);
    rd_one("gap_byte", 8'hBC);
    chk("gap_empty", empty, 1);

    // Fill to capacity, then overflow with a simultaneous read
    for (int i = 0; i < 64; i++) put_byte(8'(i), 1'b0);
    chk("fill_level", level, 64);
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 0);
    put_byte(8'hFF, 1'b1);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_level", level, 63);
    chk("ovf_rd_oldest", data_out, 8'h00);
    chk("ovf_full_clear", full, 0);
    for (int i = 1; i < 64; i++) rd_one("drain", 8'(i));
    chk("drain_empty", empty, 1);
    chk("drain_ovf_held", overflow, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("no_ff_vld", data_valid, 0);
    chk("no_ff_dout", data_out, 8'h3F);

    // Simultaneous read and write at level 5
    for (int i = 0; i < 5; i++) put_byte(8'h50 + 8'(i), 1'b0);
    chk("sim_level5", level, 5);
    for (int k = 0; k < 10; k++) begin
      put_byte(8'h55 + 8'(k), 1'b1);
      chk("sim_level", level, 5);
      chk("sim_vld", data_valid, 1);
      chk("sim_data", data_out, 8'h50 + 8'(k));
    end
    for (int i = 0; i < 5; i++) rd_one("sim_drain", 8'h5A + 8'(i));
    chk("sim_empty", empty, 1);

    // rd_en while empty
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("empty_rd_vld", data_valid, 0);
      chk("empty_rd_dout", data_out, 8'h5E);
      chk("empty_rd_level", level, 0);
    end
    rd_en = 1'b0;

    // Reset mid-byte with buffered data and concurrent activity
    put_byte(8'h11, 1'b0);
    put_byte(8'h22, 1'b0);
    put_byte(8'h33, 1'b0);
    sym(5'h1C, 1'b0);
    chk("prerst_level", level, 3);
    reset = 1'b1;
    mod_en = 1'b1;
    dmod = 5'h05;
    rd_en = 1'b1;
    tick();
    reset = 1'b0;
    mod_en = 1'b0;
    rd_en = 1'b0;
    chk_reset_state("midrst");
    sym(5'h05, 1'b0);
    chk("postrst_ferr", frame_err, 1);
    chk("postrst_cnt", err_cnt, 1);
    chk("postrst_level", level, 0);
    chk("postrst_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
